pipe_ctrl: RTL

Pipeline control unit that drives the `ld`/`flush` inputs of the four pipeline latches (IF/ID, ID/EX, EX/M, M/WB) and the PC load enable. It resolves load-use stalls, branch squashes, halt draining and optional memory wait, so the latches are only ever loaded or flushed by one central block. Outputs are Mealy: combinational from the registered state plus current hazard inputs, valid before the edge at which the latches sample them.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline control unit: state encoding, drain default, counter width.
package pipe_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    localparam int DRAIN_CYCLES_DEF = 2;
    localparam int CNT_W            = 2;

endpackage

// File: rtl/pipe_ctrl.sv
// Central load/flush control for the IF/ID, ID/EX, EX/M, M/WB latches and PC.
// Optional memory-wait freeze is compiled in with PIPE_MEMWAIT_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_use,
    input  logic br_taken,
    input  logic hlt_ex,
`ifdef PIPE_MEMWAIT_EN
    input  logic mem_busy,
`endif
    output logic pc_ld,
    output logic ifid_ld,
    output logic idex_ld,
    output logic exm_ld,
    output logic mwb_ld,
    output logic ifid_flush,
    output logic idex_flush,
    output logic exm_flush,
    output logic mwb_flush,
    output logic halted
);

    logic [1:0]       state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             busy;

`ifdef PIPE_MEMWAIT_EN
    assign busy = mem_busy;
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            halted <= (nxt_state == ST_HALT);
        end
    end

    // Mealy outputs; everything is held low while reset is asserted.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        pc_ld      = 1'b0;
        ifid_ld    = 1'b0;
        idex_ld    = 1'b0;
        exm_ld     = 1'b0;
        mwb_ld     = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exm_flush  = 1'b0;
        mwb_flush  = 1'b0;
        if (reset) begin
            case (state)
                ST_RUN, ST_BUBBLE: begin
                    if (busy) begin
                        nxt_state = state;
                    end else if (hlt_ex) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exm_ld     = 1'b1;
                        mwb_ld     = 1'b1;
                        nxt_cnt    = CNT_W'(DRAIN_CYCLES - 1);
                        nxt_state  = ST_DRAIN;
                    end else if (br_taken) begin
                        pc_ld      = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exm_ld     = 1'b1;
                        mwb_ld     = 1'b1;
                        nxt_state  = ST_RUN;
                    end else if (load_use && state == ST_RUN) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX.
                        idex_flush = 1'b1;
                        exm_ld     = 1'b1;
                        mwb_ld     = 1'b1;
                        nxt_state  = ST_BUBBLE;
                    end else begin
                        pc_ld     = 1'b1;
                        ifid_ld   = 1'b1;
                        idex_ld   = 1'b1;
                        exm_ld    = 1'b1;
                        mwb_ld    = 1'b1;
                        nxt_state = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exm_ld     = 1'b1;
                        mwb_ld     = 1'b1;
                        if (cnt == '0) nxt_state = ST_HALT;
                        else           nxt_cnt   = cnt - CNT_W'(1);
                    end
                end
                default: nxt_state = ST_HALT;
            endcase
        end
    end

endmodule
